// File: rtl/zigbee_phy_pkg.sv
// Shared ZigBee PHY constants: chip shaping, sample and accumulator widths,
// and the half-sine pulse table used by both the transmitter and receiver.
package zigbee_phy_pkg;

    localparam int SAMPLES_PER_CHIP = 10;
    localparam int SAMPLE_W         = 10;
    localparam int ACC_W            = 21;
    localparam int COEF_W           = 9;

    // Half-sine pulse, 8 fractional bits (256 = 1.0 at the chip centre).
    localparam logic [COEF_W-1:0] HALF_SINE_COEF [SAMPLES_PER_CHIP] = '{
        9'd0, 9'd79, 9'd150, 9'd207, 9'd243, 9'd256, 9'd243, 9'd207, 9'd150, 9'd79
    };

    // Table lookup that yields 0 for any index past the end of the pulse.
    function automatic logic [COEF_W-1:0] half_sine_coef(input logic [3:0] idx);
        if (int'(idx) < SAMPLES_PER_CHIP) begin
            return HALF_SINE_COEF[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/pulse_matched_mac.sv
// Matched-filter datapath: sign-magnitude conversion, tap multiply and
// per-chip accumulation. Emits the completed correlation combinationally
// on the cycle the last sample of a chip arrives.
module pulse_matched_mac
    import zigbee_phy_pkg::*;
#(
    parameter int CHIP_LEN = SAMPLES_PER_CHIP
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [SAMPLE_W-1:0]     i_sample,
    input  logic                    i_sample_valid,
    input  logic                    i_flush,
    output logic [3:0]              o_phase,
    output logic                    o_final_valid,
    output logic signed [ACC_W-1:0] o_final
);

    logic [3:0]              phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] sample_s;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] coef_ext;
    logic signed [ACC_W-1:0] product;

    // Convert the sample to two's complement (both zeros map to 0) and weight it by the current tap.
    always_comb begin
        if (i_sample[SAMPLE_W-1]) begin
            sample_s = -$signed({1'b0, i_sample[SAMPLE_W-2:0]});
        end else begin
            sample_s = $signed({1'b0, i_sample[SAMPLE_W-2:0]});
        end
        sample_ext = ACC_W'(sample_s);
        coef_ext   = ACC_W'($signed({1'b0, half_sine_coef(phase_q)}));
        product    = sample_ext * coef_ext;
        o_final    = acc_q + product;
    end

    // Advance phase and accumulator on valid samples; flush or chip end restarts both.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        phase_d       = phase_q;
        acc_d         = acc_q;
        o_final_valid = 1'b0;
        if (i_flush) begin
            phase_d = '0;
            acc_d   = '0;
        end else if (i_sample_valid) begin
            if (phase_q == 4'(CHIP_LEN - 1)) begin
                phase_d       = '0;
                acc_d         = '0;
                o_final_valid = 1'b1;
            end else begin
                phase_d = phase_q + 4'd1;
                acc_d   = o_final;
            end
        end
    end

    // Phase and accumulator registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
        if (i_rst) begin
            phase_q <= '0;
            acc_q   <= '0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
        end
    end

    assign o_phase = phase_q;

endmodule

// File: rtl/pulse_matched_filter.sv
// Half-sine matched filter for one O-QPSK rail: correlates each chip,
// registers a hard decision with a confidence flag, and hands it downstream
// through a valid/ready pair with a sticky overflow on lost decisions.
module pulse_matched_filter #(
    parameter int SAMPLES_PER_CHIP = zigbee_phy_pkg::SAMPLES_PER_CHIP,
    parameter int CONF_THRESH      = 81704
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_sample,
    input  logic       i_sample_valid,
    input  logic       i_flush,
    output logic       o_bit,
    output logic       o_bit_valid,
    input  logic       i_bit_ready,
    output logic       o_low_conf,
    output logic       o_overflow,
    output logic [3:0] o_chip_phase
);

    localparam int ACC_W = zigbee_phy_pkg::ACC_W;

    logic                    final_valid;
    logic signed [ACC_W-1:0] final_value;
    logic [ACC_W-1:0]        final_abs;

    logic bit_q, bit_d;
    logic bit_valid_q, bit_valid_d;
    logic low_conf_q, low_conf_d;
    logic overflow_q, overflow_d;

    pulse_matched_mac #(
        .CHIP_LEN (SAMPLES_PER_CHIP)
    ) u_mac (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .i_flush        (i_flush),
        .o_phase        (o_chip_phase),
        .o_final_valid  (final_valid),
        .o_final        (final_value)
    );

    // Decide the chip, then either load it, or drop it and flag overflow if the output is still held.
    always_comb begin
        final_abs   = final_value[ACC_W-1] ? ACC_W'(-final_value) : ACC_W'(final_value);
        bit_d       = bit_q;
        bit_valid_d = bit_valid_q;
        low_conf_d  = low_conf_q;
        overflow_d  = overflow_q;
        if (bit_valid_q && i_bit_ready) begin
            bit_valid_d = 1'b0;
        end
        if (final_valid) begin
            if (bit_valid_q && !i_bit_ready) begin
                overflow_d = 1'b1;
            end else begin
                bit_d       = !final_value[ACC_W-1] && (final_value != '0);
                low_conf_d  = final_abs < ACC_W'(CONF_THRESH);
                bit_valid_d = 1'b1;
            end
        end
    end

    // Decision and flag registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            low_conf_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            low_conf_q  <= low_conf_d;
            overflow_q  <= overflow_d;
        end
    end

    assign o_bit       = bit_q;
    assign o_bit_valid = bit_valid_q;
    assign o_low_conf  = low_conf_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_matched_filter.sv
// Directed + randomized bench for pulse_matched_filter against an integer
// model of chip correlation, decision and handshake behaviour.
module tb_pulse_matched_filter;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [9:0] i_sample = '0;
    logic       i_sample_valid = 1'b0;
    logic       i_flush = 1'b0;
    logic       i_bit_ready = 1'b0;
    logic       o_bit, o_bit_valid, o_low_conf, o_overflow;
    logic [3:0] o_chip_phase;

    int checks   = 0;
    int failures = 0;

    localparam int COEF_REF [10] = '{0, 79, 150, 207, 243, 256, 243, 207, 150, 79};
    localparam int THRESH = 81704;

    // Model state: samples collected for the current chip plus the output registers.
    int q_chip [$];
    int m_bit, m_valid, m_low, m_ovf;
    int last_final;
    int dec_count;

    pulse_matched_filter dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .i_flush        (i_flush),
        .o_bit          (o_bit),
        .o_bit_valid    (o_bit_valid),
        .i_bit_ready    (i_bit_ready),
        .o_low_conf     (o_low_conf),
        .o_overflow     (o_overflow),
        .o_chip_phase   (o_chip_phase)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int to_int(input logic [9:0] s);
        int mag;
        mag = int'(s[8:0]);
        return s[9] ? -mag : mag;
    endfunction

    task automatic model_reset();
        q_chip.delete();
        m_bit = 0; m_valid = 0; m_low = 0; m_ovf = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, int'(o_bit_valid), m_valid);
        check({tag, ".bit"},   int'(o_bit), m_bit);
        check({tag, ".low"},   int'(o_low_conf), m_low);
        check({tag, ".ovf"},   int'(o_overflow), m_ovf);
        check({tag, ".phase"}, int'(o_chip_phase), q_chip.size());
    endtask

    // One clock: drive inputs, advance the model, sample outputs 1 ns after the edge.
    task automatic cycle(input logic [9:0] s, input logic v, input logic f, input logic r, input string tag);
        int fin;
        bit dec;
        i_sample = s; i_sample_valid = v; i_flush = f; i_bit_ready = r;
        dec = 0;
        if (f) q_chip.delete();
        else if (v) begin
            q_chip.push_back(to_int(s));
            if (q_chip.size() == 10) begin
                fin = 0;
                foreach (q_chip[k]) fin += q_chip[k] * COEF_REF[k];
                q_chip.delete();
                dec = 1;
                last_final = fin;
            end
        end
        if (dec && m_valid == 1 && !r) m_ovf = 1;
        else if (dec) begin
            m_bit = (fin > 0) ? 1 : 0;
            m_low = ((fin < 0 ? -fin : fin) < THRESH) ? 1 : 0;
            m_valid = 1;
        end else if (m_valid == 1 && r) m_valid = 0;
        @(posedge i_clk);
        #1;
        if (o_bit_valid) dec_count++;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        i_rst = 1'b1;
        model_reset();
        cycle('0, 1'b0, 1'b0, 1'b0, tag);
        i_rst = 1'b0;
    endtask

    task automatic send_chip(input int mag_tbl [10], input logic neg, input logic r, input string tag);
        for (int i = 0; i < 10; i++)
            cycle({neg, 9'(mag_tbl[i])}, 1'b1, 1'b0, r, tag);
    endtask

    initial begin
        int ideal [10];
        int m20 [10];
        int zero [10];
        int r;
        ideal = COEF_REF;
        foreach (m20[i]) m20[i] = 20;
        foreach (zero[i]) zero[i] = 0;

        // Reset state
        do_reset("reset");
        check("reset.bit_valid", int'(o_bit_valid), 0);
        check("reset.phase", int'(o_chip_phase), 0);

        // Ideal positive chip, ready high: decision visible for exactly one cycle
        for (int i = 0; i < 9; i++) cycle(10'(ideal[i]), 1'b1, 1'b0, 1'b1, "pos");
        check("pos.pre_valid", int'(o_bit_valid), 0);
        cycle(10'(ideal[9]), 1'b1, 1'b0, 1'b1, "pos.last");
        check("pos.final", last_final, 326814);
        check("pos.dut_valid", int'(o_bit_valid), 1);
        check("pos.dut_bit", int'(o_bit), 1);
        check("pos.dut_low", int'(o_low_conf), 0);
        cycle('0, 1'b0, 1'b0, 1'b1, "pos.after");
        check("pos.dut_drop", int'(o_bit_valid), 0);

        // Negative chip with a 3-cycle gap after the fifth sample
        for (int i = 0; i < 5; i++) cycle({1'b1, 9'(ideal[i])}, 1'b1, 1'b0, 1'b1, "neg");
        for (int i = 0; i < 3; i++) begin
            cycle('0, 1'b0, 1'b0, 1'b1, "neg.gap");
            check("neg.gap_phase", int'(o_chip_phase), 5);
        end
        for (int i = 5; i < 10; i++) cycle({1'b1, 9'(ideal[i])}, 1'b1, 1'b0, 1'b1, "neg");
        check("neg.dut_bit", int'(o_bit), 0);
        check("neg.dut_low", int'(o_low_conf), 0);
        check("neg.dut_valid", int'(o_bit_valid), 1);

        // Weak chip, then negative-zero chip
        send_chip(m20, 1'b0, 1'b1, "weak");
        check("weak.final", last_final, 32280);
        check("weak.dut_bit", int'(o_bit), 1);
        check("weak.dut_low", int'(o_low_conf), 1);
        send_chip(zero, 1'b1, 1'b1, "negzero");
        check("negzero.dut_bit", int'(o_bit), 0);
        check("negzero.dut_low", int'(o_low_conf), 1);
        check("negzero.dut_valid", int'(o_bit_valid), 1);
        cycle('0, 1'b0, 1'b0, 1'b1, "idle");

        // Two chips with ready low: second decision is dropped, overflow sticks
        send_chip(ideal, 1'b0, 1'b0, "ovf.a");
        send_chip(ideal, 1'b1, 1'b0, "ovf.b");
        check("ovf.dut_bit", int'(o_bit), 1);
        check("ovf.dut_flag", int'(o_overflow), 1);
        cycle('0, 1'b0, 1'b0, 1'b1, "ovf.accept");
        cycle('0, 1'b0, 1'b0, 1'b0, "ovf.after");
        check("ovf.dut_drop", int'(o_bit_valid), 0);
        check("ovf.dut_sticky", int'(o_overflow), 1);

        // Flush after 6 samples, then a full negative chip: one decision only
        dec_count = 0;
        for (int i = 0; i < 6; i++) cycle(10'(ideal[i]), 1'b1, 1'b0, 1'b1, "flush.pre");
        cycle(10'(ideal[6]), 1'b1, 1'b1, 1'b1, "flush");
        check("flush.phase", int'(o_chip_phase), 0);
        send_chip(ideal, 1'b1, 1'b1, "flush.chip");
        cycle('0, 1'b0, 1'b0, 1'b1, "flush.idle");
        check("flush.final", last_final, -326814);
        check("flush.dec_count", dec_count, 1);
        check("flush.dut_bit", int'(o_bit), 0);

        // Reset at phase 7 while a decision is held
        do_reset("rst2.clr");
        send_chip(ideal, 1'b0, 1'b0, "rst2.fill");
        for (int i = 0; i < 7; i++) cycle(10'(ideal[i]), 1'b1, 1'b0, 1'b0, "rst2.part");
        check("rst2.pre_phase", int'(o_chip_phase), 7);
        check("rst2.pre_valid", int'(o_bit_valid), 1);
        do_reset("rst2.reset");
        check("rst2.dut_valid", int'(o_bit_valid), 0);
        check("rst2.dut_bit", int'(o_bit), 0);
        check("rst2.dut_phase", int'(o_chip_phase), 0);
        send_chip(ideal, 1'b1, 1'b1, "rst2.fresh");
        check("rst2.fresh_valid", int'(o_bit_valid), 1);
        check("rst2.fresh_bit", int'(o_bit), 0);

        // Randomized traffic: random samples, gaps, ready and rare flushes
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            cycle(10'($urandom), r < 75, r >= 98, ($urandom_range(0, 3) != 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
